// File: rtl/fsm_esc_rtc.sv
// Write-only sequencer for an RTC multiplexed bus: walks 19 address/data
// accesses, each ACC_CYCLES long, with registered (glitch-free) bus strobes.
module fsm_esc_rtc #(
   parameter int ACC_CYCLES = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic do_it_esc,
   output logic a_d,
   output logic cs,
   output logic rd,
   output logic wr,
   output logic rtc_to_reg,
   output logic reg_to_rtc,
   output logic dir_com_cyt,
   output logic dir_seg,
   output logic dat_seg,
   output logic dir_min,
   output logic dat_min,
   output logic dir_hora,
   output logic dat_hora,
   output logic dir_dia,
   output logic dat_dia,
   output logic dir_mes,
   output logic dat_mes,
   output logic dir_anio,
   output logic dat_anio,
   output logic dir_seg_tim,
   output logic dat_seg_tim,
   output logic dir_min_tim,
   output logic dat_min_tim,
   output logic dir_hora_tim,
   output logic dat_hora_tim
);
   localparam int CW   = $clog2(ACC_CYCLES);
   localparam int NACC = 19;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic [4:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            abort_q, abort_d;

   logic [NACC-1:0] sel_q, sel_d;
   logic            a_d_q, a_d_d, cs_q, cs_d, wr_q, wr_d, r2r_q, r2r_d;

   // State, access index, cycle counter and sticky abort flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   // Next state: an access always runs to its last cycle; a dropped request
   // is remembered so a re-assertion cannot resurrect the aborted sequence
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      case (state_q)
         IDLE: begin
            if (do_it_esc) begin
               state_d = ACCESS;
               idx_d   = '0;
               cnt_d   = '0;
               abort_d = 1'b0;
            end
         end
         ACCESS: begin
            abort_d = abort_q | ~do_it_esc;
            if (cnt_q == CW'(ACC_CYCLES - 1)) begin
               cnt_d = '0;
               if (abort_d) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  abort_d = 1'b0;
               end else if (idx_q == 5'(NACC - 1)) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (!do_it_esc) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            abort_d = 1'b0;
         end
      endcase
   end

   // Decode outputs from the next state so the registers line up with the
   // state/counter they describe
   always_comb begin
      sel_d = '0;
      a_d_d = 1'b1;
      cs_d  = 1'b1;
      wr_d  = 1'b1;
      r2r_d = 1'b0;
      if (state_d == ACCESS) begin
         sel_d[idx_d] = 1'b1;
         a_d_d = idx_d[0];   // odd index = data phase
         cs_d  = !(cnt_d >= CW'(1) && cnt_d <= CW'(ACC_CYCLES - 2));
         wr_d  = !(cnt_d >= CW'(2) && cnt_d <= CW'(ACC_CYCLES - 3));
         r2r_d = 1'b1;
      end
   end

   // Output registers, forced to idle values by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q <= '0;
         a_d_q <= 1'b1;
         cs_q  <= 1'b1;
         wr_q  <= 1'b1;
         r2r_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
         a_d_q <= a_d_d;
         cs_q  <= cs_d;
         wr_q  <= wr_d;
         r2r_q <= r2r_d;
      end
   end

   assign a_d          = a_d_q;
   assign cs           = cs_q;
   assign wr           = wr_q;
   assign rd           = 1'b1;
   assign rtc_to_reg   = 1'b0;
   assign reg_to_rtc   = r2r_q;
   assign dir_seg      = sel_q[0];
   assign dat_seg      = sel_q[1];
   assign dir_min      = sel_q[2];
   assign dat_min      = sel_q[3];
   assign dir_hora     = sel_q[4];
   assign dat_hora     = sel_q[5];
   assign dir_dia      = sel_q[6];
   assign dat_dia      = sel_q[7];
   assign dir_mes      = sel_q[8];
   assign dat_mes      = sel_q[9];
   assign dir_anio     = sel_q[10];
   assign dat_anio     = sel_q[11];
   assign dir_seg_tim  = sel_q[12];
   assign dat_seg_tim  = sel_q[13];
   assign dir_min_tim  = sel_q[14];
   assign dat_min_tim  = sel_q[15];
   assign dir_hora_tim = sel_q[16];
   assign dat_hora_tim = sel_q[17];
   assign dir_com_cyt  = sel_q[18];
endmodule

// File: tb/tb_fsm_esc_rtc.sv
// Directed bench for fsm_esc_rtc (ACC_CYCLES = 10).
module tb_fsm_esc_rtc;
   logic clk = 1'b0;
   logic reset, do_it_esc;
   logic a_d, cs, rd, wr, rtc_to_reg, reg_to_rtc, dir_com_cyt;
   logic dir_seg, dat_seg, dir_min, dat_min, dir_hora, dat_hora;
   logic dir_dia, dat_dia, dir_mes, dat_mes, dir_anio, dat_anio;
   logic dir_seg_tim, dat_seg_tim, dir_min_tim, dat_min_tim, dir_hora_tim, dat_hora_tim;

   int vectors = 0;
   int miscompares = 0;

   // {sel[18:0], a_d, cs, wr, reg_to_rtc, rd, rtc_to_reg}
   localparam logic [24:0] IDLE_V = {19'b0, 6'b111010};

   fsm_esc_rtc #(.ACC_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .do_it_esc(do_it_esc),
      .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
      .rtc_to_reg(rtc_to_reg), .reg_to_rtc(reg_to_rtc), .dir_com_cyt(dir_com_cyt),
      .dir_seg(dir_seg), .dat_seg(dat_seg), .dir_min(dir_min), .dat_min(dat_min),
      .dir_hora(dir_hora), .dat_hora(dat_hora), .dir_dia(dir_dia), .dat_dia(dat_dia),
      .dir_mes(dir_mes), .dat_mes(dat_mes), .dir_anio(dir_anio), .dat_anio(dat_anio),
      .dir_seg_tim(dir_seg_tim), .dat_seg_tim(dat_seg_tim),
      .dir_min_tim(dir_min_tim), .dat_min_tim(dat_min_tim),
      .dir_hora_tim(dir_hora_tim), .dat_hora_tim(dat_hora_tim)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] sel_obs();
      return {dir_com_cyt, dat_hora_tim, dir_hora_tim, dat_min_tim, dir_min_tim,
              dat_seg_tim, dir_seg_tim, dat_anio, dir_anio, dat_mes, dir_mes,
              dat_dia, dir_dia, dat_hora, dir_hora, dat_min, dir_min, dat_seg, dir_seg};
   endfunction

   function automatic logic [24:0] obs();
      return {sel_obs(), a_d, cs, wr, reg_to_rtc, rd, rtc_to_reg};
   endfunction

   // Expected outputs for access k at counter c (10-cycle accesses)
   function automatic logic [24:0] exp_acc(int k, int c);
      logic [18:0] s;
      logic e_cs, e_wr;
      s    = 19'd1 << k;
      e_cs = (c >= 1 && c <= 8) ? 1'b0 : 1'b1;
      e_wr = (c >= 2 && c <= 7) ? 1'b0 : 1'b1;
      return {s, (k % 2 == 1), e_cs, e_wr, 1'b1, 1'b1, 1'b0};
   endfunction

   // Bus invariants every cycle while out of reset
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         vectors++;
         if ($countones(sel_obs()) > 1 || rd !== 1'b1 || rtc_to_reg !== 1'b0 ||
             (wr === 1'b0 && cs !== 1'b0)) begin
            miscompares++;
            $display("FAIL monitor t=%0t sel=%b rd=%b rtc_to_reg=%b cs=%b wr=%b",
                     $time, sel_obs(), rd, rtc_to_reg, cs, wr);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      do_it_esc = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), IDLE_V);
         end
      end
   endtask

   // Full 19-access run, then DONE held while the request stays high
   task automatic run_full(string name);
      logic [9:0] cs_pat, wr_pat;
      cs_pat = 10'b1000000001;
      wr_pat = 10'b1100000011;
      for (int j = 0; j < 190; j++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== exp_acc(j / 10, j % 10)) begin
            miscompares++;
            $display("FAIL %s j=%0d got=%b exp=%b", name, j, obs(), exp_acc(j / 10, j % 10));
         end
         if (j < 10) begin
            vectors++;
            if (cs !== cs_pat[j] || wr !== wr_pat[j] || dir_seg !== 1'b1 || a_d !== 1'b0) begin
               miscompares++;
               $display("FAIL %s_first c=%0d cs=%b wr=%b dir_seg=%b a_d=%b exp cs=%b wr=%b",
                        name, j, cs, wr, dir_seg, a_d, cs_pat[j], wr_pat[j]);
            end
         end
      end
      repeat (5) begin
         @(negedge clk);
         vectors++;
         if (obs() !== IDLE_V) begin
            miscompares++;
            $display("FAIL %s_done got=%b exp=%b", name, obs(), IDLE_V);
         end
      end
   endtask

   task automatic test_full_sequence();
      @(negedge clk);
      reset = 1'b1;  // request already high: start on first edge
      run_full("full_seq");
   endtask

   task automatic test_restart();
      do_it_esc = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs() !== IDLE_V) begin
         miscompares++;
         $display("FAIL restart_gap got=%b exp=%b", obs(), IDLE_V);
      end
      do_it_esc = 1'b1;
      run_full("restart");
   endtask

   task automatic test_abort();
      do_it_esc = 1'b0;
      repeat (2) @(negedge clk);
      do_it_esc = 1'b1;
      for (int j = 0; j < 70; j++) begin
         @(negedge clk);
         vectors++;
         if (j < 40) begin
            if (obs() !== exp_acc(j / 10, j % 10)) begin
               miscompares++;
               $display("FAIL abort_run j=%0d got=%b exp=%b", j, obs(), exp_acc(j / 10, j % 10));
            end
         end else if (obs() !== IDLE_V || dir_hora !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle j=%0d got=%b exp=%b", j, obs(), IDLE_V);
         end
         if (j == 34) do_it_esc = 1'b0;  // drop at counter 4 of dat_min
      end
   endtask

   task automatic test_abort_reassert();
      logic [24:0] e;
      do_it_esc = 1'b1;
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         if (j < 10)       e = exp_acc(0, j);
         else if (j == 10) e = IDLE_V;
         else              e = exp_acc((j - 11) / 10, (j - 11) % 10);
         vectors++;
         if (obs() !== e) begin
            miscompares++;
            $display("FAIL abort_reassert j=%0d got=%b exp=%b", j, obs(), e);
         end
         if (j == 5) do_it_esc = 1'b0;
         if (j == 7) do_it_esc = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      #3 reset = 1'b0;
      #1;
      vectors++;
      if (obs() !== IDLE_V) begin
         miscompares++;
         $display("FAIL async_reset got=%b exp=%b", obs(), IDLE_V);
      end
      @(negedge clk);
      vectors++;
      if (obs() !== IDLE_V) begin
         miscompares++;
         $display("FAIL async_reset_hold got=%b exp=%b", obs(), IDLE_V);
      end
      reset = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== exp_acc(j / 10, j % 10)) begin
            miscompares++;
            $display("FAIL reset_restart j=%0d got=%b exp=%b", j, obs(), exp_acc(j / 10, j % 10));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_restart();
      test_abort();
      test_abort_reassert();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fsm_esc_rtc.md
FSM_ESC_RTC -- requirements
Module: fsm_esc_rtc

Interface
REQ-001 SHALL have parameter: ACC_CYCLES, default 10, clock cycles per bus access (legal >= 6).
REQ-002 SHALL have port: clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: do_it_esc  input  1  write-sequence request, level-sensitive.
REQ-005 SHALL have ports: a_d, cs, rd, wr  output  1 each  RTC multiplexed-bus controls, all active-low; a_d=0 means address phase, a_d=1 means data phase.
REQ-006 SHALL have ports: rtc_to_reg, reg_to_rtc  output  1 each  bus-direction enables; rtc_to_reg means read capture, reg_to_rtc means drive bus from registers.
REQ-007 SHALL have port: dir_com_cyt  output  1  selects command address (clock/timer transfer).
REQ-008 SHALL have ports: dir_X / dat_X  output  1 each, for X in seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim; dir_X selects address of register X, dat_X selects its data.

Function
REQ-009 SHALL be a write-only sequencer; rd SHALL be constant 1 and rtc_to_reg constant 0.
REQ-010 SHALL have states IDLE, ACCESS (with access index 0..18 and cycle counter 0..ACC_CYCLES-1), DONE.
REQ-011 In IDLE, when do_it_esc=1, SHALL enter ACCESS at index 0, counter 0 on the next edge.
REQ-012 Access order SHALL be: dir_seg, dat_seg, dir_min, dat_min, dir_hora, dat_hora, dir_dia, dat_dia, dir_mes, dat_mes, dir_anio, dat_anio, dir_seg_tim, dat_seg_tim, dir_min_tim, dat_min_tim, dir_hora_tim, dat_hora_tim, dir_com_cyt (19 accesses).
REQ-013 During the whole access, exactly that access's select line SHALL be 1 and all other select lines 0; outside ACCESS all select lines SHALL be 0.
REQ-014 During an access, a_d SHALL be 0 for dir_* accesses and 1 for dat_* accesses; reg_to_rtc SHALL be 1 for every counter value.
REQ-015 Per access, cs SHALL be 0 for counter 1..ACC_CYCLES-2 and 1 otherwise.
REQ-016 Per access, wr SHALL be 0 for counter 2..ACC_CYCLES-3 and 1 otherwise.
REQ-017 At counter ACC_CYCLES-1, the FSM SHALL advance to the next index at counter 0; after index 18 it SHALL enter DONE.
REQ-018 All outputs SHALL be registered (glitch-free); output values SHALL correspond to the current state and counter.
REQ-019 In DONE, the outputs SHALL equal the IDLE values; the FSM SHALL stay in DONE while do_it_esc=1 and go to IDLE when do_it_esc=0 (one sequence per request).
REQ-020 If do_it_esc falls during ACCESS, the current access SHALL complete unchanged through counter ACC_CYCLES-1, then go to IDLE, starting no further access.
REQ-021 If do_it_esc is re-asserted before that abort completes, the sequence SHALL still end in IDLE; a new sequence SHALL start from index 0 afterwards.
REQ-022 Idle-value outputs: a_d=1, cs=1, rd=1, wr=1, rtc_to_reg=0, reg_to_rtc=0, all select lines 0.

Reset
REQ-023 When reset=0, the FSM SHALL asynchronously enter IDLE, clear the index/counter, and drive idle-value outputs, including mid-access.
REQ-024 After reset releases with do_it_esc already 1, the sequence SHALL start on the first rising edge after release.

Verification
REQ-025 do_it_esc=1 held, reset released -> 19 accesses of 10 cycles each in REQ-012 order, then DONE with idle-value outputs.
REQ-026 First access, counter 0..9 -> dir_seg=1, a_d=0, reg_to_rtc=1, cs pattern 1,0,0,0,0,0,0,0,0,1, wr pattern 1,1,0,0,0,0,0,0,1,1.
REQ-027 Monitor every cycle -> at most one select line high, rd=1, rtc_to_reg=0, wr=0 only when cs=0.
REQ-028 do_it_esc dropped at counter 4 of dat_min -> dat_min access completes (cs/wr waveform intact), then IDLE; dir_hora never asserted.
REQ-029 DONE then do_it_esc=0 for 1 cycle then 1 -> new full sequence starting at dir_seg.
REQ-030 reset=0 asserted mid-access -> outputs take idle values immediately, without waiting for a clock edge.
